// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encoding and default timing.
// Display and LED decode logic import this so all blocks agree on the state values.
package stopwatch_ctrl_pkg;

    localparam int STATE_W             = 3;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int TICK_DIV_DEF        = 500_000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_RUNNING = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_LAP     = 3'd3,
        ST_DONE    = 3'd4
    } sw_state_e;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Board-side signal bundle of the stopwatch controller: raw keys and saturation flag in,
// counter strobes, display freeze and state out.
interface stopwatch_ctrl_if;

    logic                                  key_start_n;
    logic                                  key_lap_n;
    logic                                  key_reset_n;
    logic                                  at_max;
    logic                                  count_en;
    logic                                  counter_clr;
    logic                                  display_freeze;
    logic [stopwatch_ctrl_pkg::STATE_W-1:0] state;

    modport master (
        output key_start_n, key_lap_n, key_reset_n, at_max,
        input  count_en, counter_clr, display_freeze, state
    );

    modport slave (
        input  key_start_n, key_lap_n, key_reset_n, at_max,
        output count_en, counter_clr, display_freeze, state
    );

endinterface

// File: rtl/stopwatch_ctrl_key_debouncer.sv
// One pushbutton: 2-FF synchronizer, stability counter, and a one-cycle press pulse
// on each accepted released->pressed transition.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = stopwatch_ctrl_pkg::DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced keys sequence the run/pause/lap/done states and a
// 100 Hz divider produces the counter increment strobe.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TICK_DIV        = TICK_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    stopwatch_ctrl_if.slave   bus
);

    localparam int                DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic start_press, lap_press, reset_press;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
        .clk(clk), .rst_n(rst_n), .key_n_i(bus.key_start_n), .press_o(start_press)
    );
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lap (
        .clk(clk), .rst_n(rst_n), .key_n_i(bus.key_lap_n), .press_o(lap_press)
    );
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_reset (
        .clk(clk), .rst_n(rst_n), .key_n_i(bus.key_reset_n), .press_o(reset_press)
    );

    sw_state_e        state_q;
    logic [DIV_W-1:0] div_q;
    logic             count_en_q, counter_clr_q, freeze_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            count_en_q    <= 1'b0;
            counter_clr_q <= 1'b0;
            freeze_q      <= 1'b0;
        end else begin
            count_en_q    <= 1'b0;
            counter_clr_q <= 1'b0;
            if (reset_press) begin
                state_q       <= ST_IDLE;
                div_q         <= '0;
                counter_clr_q <= 1'b1;
                freeze_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        div_q    <= '0;
                        freeze_q <= 1'b0;
                        if (start_press) state_q <= ST_RUNNING;
                    end
                    ST_RUNNING, ST_LAP: begin
                        if (bus.at_max) begin
                            state_q  <= ST_DONE;
                            div_q    <= '0;
                            freeze_q <= 1'b0;
                        end else if (start_press) begin
                            state_q  <= ST_PAUSED;
                            freeze_q <= 1'b0;
                            // A tick falling due on the pausing edge is held back until after resume.
                            if (div_q != DIV_LAST) div_q <= div_q + 1'b1;
                        end else begin
                            if (lap_press) begin
                                state_q  <= (state_q == ST_RUNNING) ? ST_LAP : ST_RUNNING;
                                freeze_q <= (state_q == ST_RUNNING);
                            end
                            if (div_q == DIV_LAST) begin
                                div_q      <= '0;
                                count_en_q <= 1'b1;
                            end else begin
                                div_q <= div_q + 1'b1;
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (start_press) state_q <= ST_RUNNING;
                    end
                    ST_DONE: begin
                        div_q    <= '0;
                        freeze_q <= 1'b0;
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        div_q    <= '0;
                        freeze_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.state          = state_q;
    assign bus.count_en       = count_en_q;
    assign bus.counter_clr    = counter_clr_q;
    assign bus.display_freeze = freeze_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized key/at_max
// traffic, all compared against a cycle-level behavioural model of the stopwatch rules.
module tb_stopwatch_ctrl;

    localparam int DEB  = 4;
    localparam int TDIV = 5;
    localparam logic [2:0] M_IDLE = 3'd0, M_RUN = 3'd1, M_PAUSE = 3'd2, M_LAP = 3'd3, M_DONE = 3'd4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
        .clk(clk), .rst_n(rst_n), .bus(sw)
    );

    always #5 clk = ~clk;

    logic [5:0] dut_vec;
    assign dut_vec = {sw.state, sw.count_en, sw.counter_clr, sw.display_freeze};

    // Reference model: key history windows and stopwatch state after the latest edge.
    logic [2:0]     m_state;
    logic           m_cen, m_clr, m_frz;
    int             m_phase;
    logic           m_deb[3];
    logic           m_press[3];
    logic [1:0]     m_pipe[3];
    logic [DEB-1:0] m_win[3];

    function automatic logic [5:0] exp_vec();
        return {m_state, m_cen, m_clr, m_frz};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_cen = 1'b0; m_clr = 1'b0; m_frz = 1'b0;
        m_phase = 0;
        for (int k = 0; k < 3; k++) begin
            m_deb[k] = 1'b1; m_press[k] = 1'b0; m_pipe[k] = 2'b11; m_win[k] = '1;
        end
    endtask

    task automatic model_step();
        logic raw[3];
        logic pnow[3];
        logic sync, sp, lp, rp, was_run;
        logic [2:0] nxt;
        raw[0] = sw.key_start_n; raw[1] = sw.key_lap_n; raw[2] = sw.key_reset_n;
        sp = m_press[0]; lp = m_press[1]; rp = m_press[2];
        // A key level is accepted once the last DEB synchronized samples all disagree with it.
        for (int k = 0; k < 3; k++) begin
            sync = m_pipe[k][1];
            m_pipe[k] = {m_pipe[k][0], raw[k]};
            m_win[k] = {m_win[k][DEB-2:0], sync};
            pnow[k] = 1'b0;
            if (m_win[k] == {DEB{~m_deb[k]}}) begin
                pnow[k] = m_deb[k];
                m_deb[k] = ~m_deb[k];
            end
        end
        m_cen = 1'b0; m_clr = 1'b0;
        nxt = m_state;
        was_run = (m_state == M_RUN) || (m_state == M_LAP);
        if (rp) begin
            nxt = M_IDLE; m_clr = 1'b1; m_phase = 0; m_frz = 1'b0;
        end else if (was_run && sw.at_max) begin
            nxt = M_DONE; m_phase = 0; m_frz = 1'b0;
        end else begin
            if (sp && m_state != M_DONE) begin
                case (m_state)
                    M_IDLE:  begin nxt = M_RUN; m_phase = 0; end
                    M_RUN:   nxt = M_PAUSE;
                    M_LAP:   begin nxt = M_PAUSE; m_frz = 1'b0; end
                    M_PAUSE: nxt = M_RUN;
                    default: nxt = M_IDLE;
                endcase
            end else if (lp && was_run) begin
                nxt = (m_state == M_RUN) ? M_LAP : M_RUN;
                m_frz = (nxt == M_LAP);
            end
            if (was_run) begin
                if (nxt == M_PAUSE) begin
                    if (m_phase < TDIV - 1) m_phase++;
                end else begin
                    m_phase++;
                    if (m_phase == TDIV) begin m_phase = 0; m_cen = 1'b1; end
                end
            end
        end
        m_state = nxt;
        for (int k = 0; k < 3; k++) m_press[k] = pnow[k];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_key(int k, logic v);
        case (k)
            0:       sw.key_start_n = v;
            1:       sw.key_lap_n   = v;
            default: sw.key_reset_n = v;
        endcase
    endtask

    task automatic drive_press(int k, int hold, int settle);
        set_key(k, 1'b0);
        repeat (hold) tick();
        set_key(k, 1'b1);
        repeat (settle) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw.key_start_n = 1'b1; sw.key_lap_n = 1'b1; sw.key_reset_n = 1'b1; sw.at_max = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (dut_vec !== 6'b0) begin
            errors++; $display("FAIL reset_state: got %b want 000000", dut_vec);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL reset_idle cyc %0d: got %b want %b", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_start();
        int entry = -1;
        int pulses[$];
        set_key(0, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 10) set_key(0, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL start_model cyc %0d: got %b want %b", i, dut_vec, exp_vec());
            end
            if (entry < 0 && sw.state == M_RUN) entry = i;
            if (sw.count_en) pulses.push_back(i);
        end
        checks++;
        if (entry < 0 || entry > 7) begin
            errors++; $display("FAIL start_latency: got %0d cycles want 1..7", entry);
        end
        checks++;
        if (pulses.size() < 4 || pulses[0] - entry != TDIV) begin
            errors++; $display("FAIL start_first_pulse: got %0d pulses, first at %0d, entry %0d", pulses.size(), (pulses.size() > 0) ? pulses[0] : -1, entry);
        end
        for (int k = 1; k < pulses.size(); k++) begin
            checks++;
            if (pulses[k] - pulses[k-1] != TDIV) begin
                errors++; $display("FAIL start_spacing: got %0d want %0d", pulses[k] - pulses[k-1], TDIV);
            end
        end
        checks++;
        if (sw.state !== M_RUN) begin
            errors++; $display("FAIL start_single_press: got state %0d want 1", sw.state);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== 6'b0) begin
            errors++; $display("FAIL async_reset: got %b want 000000", dut_vec);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec() || sw.state !== M_IDLE || sw.count_en !== 1'b0) begin
                errors++; $display("FAIL reset_quiet cyc %0d: got %b want %b", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            set_key(0, ((i / 2) % 2 == 0) ? 1'b0 : 1'b1);
            tick();
            checks++;
            if (dut_vec !== exp_vec() || sw.state !== M_IDLE || sw.count_en !== 1'b0) begin
                errors++; $display("FAIL bounce cyc %0d: got %b want %b", i, dut_vec, exp_vec());
            end
        end
        set_key(0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec() || sw.state !== M_IDLE) begin
                errors++; $display("FAIL bounce_settle cyc %0d: got %b want %b", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_lap();
        int pulses[$];
        drive_press(0, 8, 4);
        set_key(1, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 8 || i == 28) set_key(1, 1'b1);
            if (i == 20) set_key(1, 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL lap_model cyc %0d: got %b want %b", i, dut_vec, exp_vec());
            end
            if (i == 10) begin
                checks++;
                if (sw.state !== M_LAP || sw.display_freeze !== 1'b1) begin
                    errors++; $display("FAIL lap_enter: got state %0d freeze %b want 3/1", sw.state, sw.display_freeze);
                end
            end
            if (i == 30) begin
                checks++;
                if (sw.state !== M_RUN || sw.display_freeze !== 1'b0) begin
                    errors++; $display("FAIL lap_exit: got state %0d freeze %b want 1/0", sw.state, sw.display_freeze);
                end
            end
            if (sw.count_en) pulses.push_back(i);
        end
        checks++;
        if (pulses.size() < 7) begin
            errors++; $display("FAIL lap_pulse_count: got %0d want >= 7", pulses.size());
        end
        for (int k = 1; k < pulses.size(); k++) begin
            checks++;
            if (pulses[k] - pulses[k-1] != TDIV) begin
                errors++; $display("FAIL lap_spacing: got %0d want %0d", pulses[k] - pulses[k-1], TDIV);
            end
        end
    endtask

    task automatic test_pause_resume();
        int guard = 0;
        int late_pulses = 0;
        int entry = -1;
        int first = -1;
        // Drive the start key so the pause lands with two cycles of the interval used.
        while (m_phase != 1 && guard < 20) begin
            tick();
            guard++;
        end
        set_key(0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 8) set_key(0, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL pause_model cyc %0d: got %b want %b", i, dut_vec, exp_vec());
            end
            if (i >= 7 && sw.count_en) late_pulses++;
            if (i == 7) begin
                checks++;
                if (sw.state !== M_PAUSE) begin
                    errors++; $display("FAIL pause_enter: got state %0d want 2", sw.state);
                end
            end
        end
        checks++;
        if (late_pulses != 0) begin
            errors++; $display("FAIL pause_quiet: got %0d pulses want 0", late_pulses);
        end
        set_key(0, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 8) set_key(0, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL resume_model cyc %0d: got %b want %b", i, dut_vec, exp_vec());
            end
            if (entry < 0 && sw.state == M_RUN) entry = i;
            if (first < 0 && sw.count_en) first = i;
        end
        checks++;
        if (entry != 7 || first - entry != 2) begin
            errors++; $display("FAIL resume_first_pulse: got entry %0d gap %0d want 7/2", entry, first - entry);
        end
    endtask

    task automatic test_at_max();
        int clr_cnt = 0;
        sw.at_max = 1'b1;
        tick();
        checks++;
        if (dut_vec !== exp_vec() || sw.state !== M_DONE) begin
            errors++; $display("FAIL at_max_done: got %b want state 4 (%b)", dut_vec, exp_vec());
        end
        for (int i = 1; i <= 20; i++) begin
            if (i == 1) set_key(0, 1'b0);
            if (i == 9) set_key(0, 1'b1);
            tick();
            checks++;
            if (dut_vec !== exp_vec() || sw.state !== M_DONE || sw.count_en !== 1'b0) begin
                errors++; $display("FAIL done_hold cyc %0d: got %b want %b", i, dut_vec, exp_vec());
            end
        end
        set_key(2, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 8) set_key(2, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL done_reset cyc %0d: got %b want %b", i, dut_vec, exp_vec());
            end
            if (sw.counter_clr) clr_cnt++;
        end
        checks++;
        if (clr_cnt != 1 || sw.state !== M_IDLE) begin
            errors++; $display("FAIL done_clear: got %0d clr pulses state %0d want 1/0", clr_cnt, sw.state);
        end
        sw.at_max = 1'b0;
    endtask

    task automatic test_simultaneous();
        int clr_cnt = 0;
        drive_press(0, 8, 6);
        set_key(0, 1'b0); set_key(2, 1'b0);
        tick();
        set_key(0, 1'b1); set_key(2, 1'b1);
        tick();
        set_key(0, 1'b0); set_key(2, 1'b0);
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 8) begin set_key(0, 1'b1); set_key(2, 1'b1); end
            checks++;
            if (dut_vec !== exp_vec() || (sw.count_en && sw.counter_clr)) begin
                errors++; $display("FAIL simul_model cyc %0d: got %b want %b", i, dut_vec, exp_vec());
            end
            if (sw.counter_clr) clr_cnt++;
        end
        checks++;
        if (clr_cnt != 1 || sw.state !== M_IDLE) begin
            errors++; $display("FAIL simul_reset_wins: got %0d clr pulses state %0d want 1/0", clr_cnt, sw.state);
        end
    endtask

    task automatic test_random();
        int   rem[3];
        logic lvl[3];
        for (int k = 0; k < 3; k++) begin
            lvl[k] = 1'b1;
            rem[k] = $urandom_range(5, 30);
            set_key(k, 1'b1);
        end
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++) begin
                rem[k]--;
                if (rem[k] <= 0) begin
                    lvl[k] = ~lvl[k];
                    if (!lvl[k])     rem[k] = $urandom_range(1, 12);
                    else if (k == 2) rem[k] = $urandom_range(20, 80);
                    else             rem[k] = $urandom_range(1, 15);
                    set_key(k, lvl[k]);
                end
            end
            sw.at_max = ($urandom_range(0, 59) == 0);
            tick();
            checks++;
            if (dut_vec !== exp_vec() || (sw.count_en && sw.counter_clr)) begin
                errors++; $display("FAIL random cyc %0d: got %b want %b", c, dut_vec, exp_vec());
            end
        end
        for (int k = 0; k < 3; k++) set_key(k, 1'b1);
        sw.at_max = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_async_reset();
        test_bounce();
        test_lap();
        test_pause_resume();
        test_at_max();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the DE10-Lite stopwatch. Debounces the KEY pushbuttons (start/stop, lap, reset) and sequences the centisecond counter datapath. Generates a one-cycle count-enable pulse at 100 Hz from the board clock, a synchronous clear, and a display-freeze flag for lap hold. Sits between the board keys and the time counter / 7-segment display path, in the single clk domain.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable clk cycles before a key level is accepted (20 ms at 50 MHz)
TICK_DIV, 500_000, clk cycles per count_en pulse (100 Hz at 50 MHz)

Ports:
clk  input  1  system clock (50 MHz on board)
rst_n  input  1  asynchronous active-low reset
key_start_n  input  1  raw start/stop key, active-low, asynchronous to clk
key_lap_n  input  1  raw lap key, active-low, asynchronous to clk
key_reset_n  input  1  raw reset key, active-low, asynchronous to clk
at_max  input  1  counter saturated at 59.99 s (level, from datapath)
count_en  output  1  one-cycle increment pulse to counter
counter_clr  output  1  one-cycle synchronous clear to counter
display_freeze  output  1  level; display holds latched digits while high
state  output  3  current FSM state (for LEDs/debug)

Behaviour:
- Reset: asynchronous on rst_n low. state=IDLE(0); count_en=0, counter_clr=0, display_freeze=0; divider=0; key synchronizers and debounced levels=1 (released).
- Per key: 2-FF synchronizer, then a stable counter. The debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any reversion resets the counter to 0. A 1->0 debounced transition gives a one-cycle press pulse. Releases generate nothing.
- Press latency: DEBOUNCE_CYCLES+2 to DEBOUNCE_CYCLES+3 cycles after the raw falling edge. Holding a key gives exactly one press.
- States: IDLE=0, RUNNING=1, PAUSED=2, LAP=3, DONE=4. Encodings 5-7 are illegal and recover to IDLE.
- Per-cycle priority: reset press > at_max > start press > lap press.
- Transitions:
  - reset press, any state -> IDLE; counter_clr=1 for exactly the next cycle; divider cleared; display_freeze=0.
  - start: IDLE->RUNNING; RUNNING->PAUSED; LAP->PAUSED with display_freeze cleared; PAUSED->RUNNING. DONE ignores start.
  - lap: RUNNING->LAP with display_freeze=1; LAP->RUNNING with display_freeze=0. Lap is ignored in all other states.
  - at_max=1 while RUNNING or LAP -> DONE; display_freeze=0. at_max is ignored in IDLE and PAUSED.
- Divider: counts 0..TICK_DIV-1 only in RUNNING or LAP. Holds its value in PAUSED, so a fractional interval is preserved across pause. Cleared in IDLE and DONE.
- count_en: registered; high for one cycle when the divider wraps from TICK_DIV-1 to 0. Never high outside RUNNING/LAP, and never in the cycle the state leaves them.
- First pulse arrives TICK_DIV cycles after entry to RUNNING from IDLE.
- Pulse spacing is exactly TICK_DIV cycles.
- count_en and counter_clr are never high in the same cycle.
- All outputs are registered; state changes one cycle after the press pulse.

Decomposition:
- Shared package: state encoding constants (ST_IDLE..ST_DONE, 3-bit width) and default DEBOUNCE_CYCLES/TICK_DIV values, so the display and LED logic decode state identically.
- One sub-module: key_debouncer (synchronizer + stable counter + press pulse, parameter DEBOUNCE_CYCLES), instantiated three times. FSM and divider stay in stopwatch_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=5):
- Assert rst_n=0 mid-count in RUNNING -> state=0, count_en=0, counter_clr=0, display_freeze=0 immediately; nothing changes after release with no keys pressed.
- Start key low for 10 cycles -> state=1 within 7 cycles of the edge; count_en pulses exactly every 5 cycles; single press registered.
- Toggle key_start_n every 2 cycles for 20 cycles, then release -> no press, state stays 0, no count_en.
- RUNNING, then lap press -> state=3, display_freeze=1, count_en keeps every-5 spacing. Second lap -> state=1, display_freeze=0.
- RUNNING with divider at 2, start press -> state=2, no count_en. Resume -> first count_en 2 cycles after re-entering RUNNING.
- at_max=1 in RUNNING -> state=4 next cycle, count_en stops, start ignored. Reset press -> counter_clr high exactly one cycle, state=0.
- Start and reset presses in the same cycle (both keys released together after bounce) -> reset wins: state=0 and counter_clr pulses.
